// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory combinationally and
// buffers {pc, instr} in a small show-ahead FIFO feeding decode, with redirect flush.
module ifetch_unit #(
  parameter int ADDRWIDTH = 32,
  parameter int DATAWIDTH = 32,
  parameter int RESET_PC  = 0,
  parameter int FETCH_END = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [ADDRWIDTH-1:0] imem_address,
  output logic                 imem_read_write,
  output logic [DATAWIDTH-1:0] imem_data_in,
  input  logic [DATAWIDTH-1:0] imem_data_out,
  output logic                 id_valid,
  input  logic                 id_ready,
  output logic [DATAWIDTH-1:0] id_instr,
  output logic [ADDRWIDTH-1:0] id_pc,
  input  logic                 redirect_valid,
  input  logic [ADDRWIDTH-1:0] redirect_target,
  output logic                 fetch_done
);

  localparam int PTRW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNTW = $clog2(BUF_DEPTH) + 1;
  localparam logic [ADDRWIDTH-1:0] END_ADDR = ADDRWIDTH'(FETCH_END);
  localparam logic [ADDRWIDTH-1:0] RST_ADDR = ADDRWIDTH'(RESET_PC);
  localparam logic [CNTW-1:0]      DEPTH_C  = CNTW'(BUF_DEPTH);

  logic [ADDRWIDTH-1:0] pc_q, pc_d;
  logic [PTRW-1:0]      rd_q, rd_d, wr_q, wr_d;
  logic [CNTW-1:0]      count_q, count_d;
  logic [ADDRWIDTH-1:0] pc_mem    [BUF_DEPTH];
  logic [DATAWIDTH-1:0] instr_mem [BUF_DEPTH];
  logic                 fetch_ok, push, pop;

  assign imem_address    = pc_q;
  assign imem_read_write = 1'b0;
  assign imem_data_in    = '0;

  assign fetch_ok   = (pc_q < END_ADDR);
  assign id_valid   = (count_q != '0);
  assign id_instr   = id_valid ? instr_mem[rd_q] : '0;
  assign id_pc      = id_valid ? pc_mem[rd_q] : '0;
  assign fetch_done = !fetch_ok && (count_q == '0);

  // A full FIFO can still accept a word when the head leaves on the same edge.
  assign pop  = id_valid && id_ready && !redirect_valid;
  assign push = !redirect_valid && fetch_ok && ((count_q < DEPTH_C) || pop);

  always_comb begin
    pc_d    = pc_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (redirect_valid) begin
      pc_d    = redirect_target & ~ADDRWIDTH'(3);
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        pc_d = pc_q + ADDRWIDTH'(4);
        wr_d = wr_q + PTRW'(1);
      end
      if (pop) begin
        rd_d = rd_q + PTRW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNTW'(1);
        2'b01:   count_d = count_q - CNTW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RST_ADDR;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: count_q gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q]    <= pc_q;
      instr_mem[wr_q] <= imem_data_out;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: stimulus queues expected {pc, instr} deliveries,
// a negedge monitor pops and compares every decode handshake.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_address;
  logic        imem_read_write;
  logic [31:0] imem_data_in;
  logic [31:0] imem_data_out;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        fetch_done;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q [$];

  ifetch_unit #(
    .ADDRWIDTH(32), .DATAWIDTH(32), .RESET_PC(0), .FETCH_END(32), .BUF_DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_address(imem_address), .imem_read_write(imem_read_write),
    .imem_data_in(imem_data_in), .imem_data_out(imem_data_out),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .fetch_done(fetch_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] addr);
    case (addr)
      32'h00:  return 32'h00940333;
      32'h04:  return 32'h413903b3;
      32'h08:  return 32'h035a02b3;
      32'h0c:  return 32'h0000a0b3;
      32'h10:  return 32'h019c1eb3;
      32'h14:  return 32'h00b50533;
      32'h18:  return 32'h40c58633;
      32'h1c:  return 32'h00f768b3;
      default: return 32'h00000013;
    endcase
  endfunction

  always_comb imem_data_out = imem_word(imem_address);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_range(input logic [31:0] first, input logic [31:0] last_excl);
    for (logic [31:0] a = first; a < last_excl; a += 4) exp_q.push_back({a, imem_word(a)});
  endtask

  task automatic reset_pulse();
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 60 && !fetch_done; i++) step(1);
    check({tag, "_fetch_done"}, 64'(fetch_done), 64'd1);
    check({tag, "_idle_valid"}, 64'(id_valid), 64'd0);
    check({tag, "_all_delivered"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // Monitor: a handshake seen at negedge is taken by the DUT on the next posedge.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      check("imem_read_write", 64'(imem_read_write), 64'd0);
      check("imem_data_in", 64'(imem_data_in), 64'd0);
      if (rst_n && id_valid && id_ready && !redirect_valid) begin
        $display("tx pc=0x%08h instr=0x%08h", id_pc, id_instr);
        if (exp_q.size() == 0) begin
          check("unexpected_delivery", {id_pc, id_instr}, 64'hffff_ffff_ffff_ffff);
        end else begin
          e = exp_q.pop_front();
          check("deliver_pc", 64'(id_pc), 64'(e[63:32]));
          check("deliver_instr", 64'(id_instr), 64'(e[31:0]));
        end
      end
    end
  end

  initial begin
    // 1: reset state, then free-running stream
    #2;
    check("rst_valid", 64'(id_valid), 64'd0);
    check("rst_instr", 64'(id_instr), 64'd0);
    check("rst_pc", 64'(id_pc), 64'd0);
    check("rst_done", 64'(fetch_done), 64'd0);
    check("rst_addr", 64'(imem_address), 64'd0);
    #10 rst_n = 1'b1;
    expect_range(32'h0, 32'h20);
    step(1);
    check("t1_first_valid", 64'(id_valid), 64'd1);
    check("t1_first_instr", 64'(id_instr), 64'h00940333);
    wait_done("t1");

    // 2: stalled decode fills the FIFO, then drains in order
    id_ready = 1'b0;
    reset_pulse();
    step(2);
    check("t2_addr_full", 64'(imem_address), 64'h8);
    check("t2_head_instr", 64'(id_instr), 64'h00940333);
    check("t2_head_pc", 64'(id_pc), 64'h0);
    step(1);
    check("t2_addr_hold", 64'(imem_address), 64'h8);
    check("t2_instr_hold", 64'(id_instr), 64'h00940333);
    expect_range(32'h0, 32'h20);
    id_ready = 1'b1;
    wait_done("t2");

    // 3: redirect to misaligned target while full
    id_ready = 1'b0;
    reset_pulse();
    step(2);
    redirect_valid = 1'b1;
    redirect_target = 32'h12;
    step(1);
    redirect_valid = 1'b0;
    check("t3_flush_valid", 64'(id_valid), 64'd0);
    check("t3_target_addr", 64'(imem_address), 64'h10);
    expect_range(32'h10, 32'h20);
    step(1);
    check("t3_first_instr", 64'(id_instr), 64'h019c1eb3);
    check("t3_first_pc", 64'(id_pc), 64'h10);
    id_ready = 1'b1;
    wait_done("t3");

    // 4: id_ready toggling every cycle
    id_ready = 1'b0;
    reset_pulse();
    expect_range(32'h0, 32'h20);
    for (int i = 0; i < 16; i++) begin
      id_ready = i[0];
      step(1);
      check("t4_count_bound", 64'(dut.count_q <= 2), 64'd1);
    end
    id_ready = 1'b1;
    wait_done("t4");

    // 5: redirect after done restarts; redirect past the end finishes at once
    redirect_valid = 1'b1;
    redirect_target = 32'h0;
    step(1);
    redirect_valid = 1'b0;
    check("t5_done_cleared", 64'(fetch_done), 64'd0);
    check("t5_restart_addr", 64'(imem_address), 64'h0);
    expect_range(32'h0, 32'h20);
    wait_done("t5");
    redirect_valid = 1'b1;
    redirect_target = 32'h40;
    step(1);
    redirect_valid = 1'b0;
    check("t5_done_high", 64'(fetch_done), 64'd1);
    check("t5_high_addr", 64'(imem_address), 64'h40);
    check("t5_high_valid", 64'(id_valid), 64'd0);

    // 6: asynchronous reset mid-stream
    id_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h0;
    step(1);
    redirect_valid = 1'b0;
    step(2);
    check("t6_prefull_valid", 64'(id_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(id_valid), 64'd0);
    check("t6_rst_instr", 64'(id_instr), 64'd0);
    check("t6_rst_pc", 64'(id_pc), 64'd0);
    check("t6_rst_addr", 64'(imem_address), 64'd0);
    rst_n = 1'b1;
    expect_range(32'h0, 32'h20);
    id_ready = 1'b1;
    wait_done("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
